// File: rtl/gate_window_sequencer.sv
// Gate-window timebase for the frequency meter: opens Gate for GATE_CYCLES, pulses Latch, then holds.
// Optional AUTO_RESTART_EN: HOLD rolls straight back into GATE until Stop is seen.
module gate_window_sequencer #(
  parameter int GATE_CYCLES = 1000,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMER_SIZE  = 16,
  parameter int MEAS_SIZE   = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Stop,
  output logic                 Gate,
  output logic                 Latch,
  output logic                 Busy,
  output logic [MEAS_SIZE-1:0] MeasCount
);

  typedef enum logic [1:0] {IDLE, GATE, LATCH, HOLD} state_t;

  localparam logic [TIMER_SIZE-1:0] GATE_LAST = TIMER_SIZE'(GATE_CYCLES - 1);
  localparam logic [TIMER_SIZE-1:0] HOLD_LAST = TIMER_SIZE'(HOLD_CYCLES - 1);

  state_t                state, state_nx;
  logic [TIMER_SIZE-1:0] timer, timer_nx;
  logic [MEAS_SIZE-1:0]  meas_nx;
  logic                  startq, start_rise;
  logic                  gate_nx, latch_nx, busy_nx;

  assign start_rise = Start & ~startq;

  // Falling-edge state so Gate/Latch settle half a period before the counter's rising edge.
  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      timer     <= '0;
      startq    <= 1'b0;
      MeasCount <= '0;
      Gate      <= 1'b0;
      Latch     <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      startq    <= Start;
      MeasCount <= meas_nx;
      Gate      <= gate_nx;
      Latch     <= latch_nx;
      Busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    meas_nx  = MeasCount;
    case (state)
      IDLE: begin
        if (start_rise && !Stop) begin
          state_nx = GATE;
          timer_nx = '0;
        end
      end
      GATE: begin
        if (Stop)                    state_nx = IDLE;
        else if (timer == GATE_LAST) state_nx = LATCH;
        else                         timer_nx = timer + TIMER_SIZE'(1);
      end
      LATCH: begin
        // An abort during the latch period must not count the window.
        if (Stop) state_nx = IDLE;
        else begin
          state_nx = HOLD;
          timer_nx = '0;
          meas_nx  = MeasCount + MEAS_SIZE'(1);
        end
      end
      HOLD: begin
        if (Stop) state_nx = IDLE;
        else if (timer == HOLD_LAST) begin
`ifdef AUTO_RESTART_EN
          state_nx = GATE;
          timer_nx = '0;
`else
          state_nx = IDLE;
`endif
        end else timer_nx = timer + TIMER_SIZE'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register on the same edge as the state.
  always_comb begin
    gate_nx  = (state_nx == GATE);
    latch_nx = (state_nx == LATCH);
    busy_nx  = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_gate_window_sequencer.sv
// Directed bench for gate_window_sequencer (GATE=10, HOLD=3, MEAS_SIZE=2); Latch events are
// checked against a scoreboard of expected gate length and pre-latch MeasCount.
module tb_gate_window_sequencer;

  localparam int GC = 10;
  localparam int HC = 3;
  localparam int MS = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          Stop = 1'b0;
  logic          Gate, Latch, Busy;
  logic [MS-1:0] MeasCount;

  typedef struct {int glen; int meas;} exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_meas = 0;

  gate_window_sequencer #(.GATE_CYCLES(GC), .HOLD_CYCLES(HC), .TIMER_SIZE(16), .MEAS_SIZE(MS)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Gate(Gate), .Latch(Latch), .Busy(Busy), .MeasCount(MeasCount)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on rising edges, away from the DUT's falling-edge updates.
  int run = 0;
  int last = 0;
  always @(posedge Clk) begin
    if (Reset) begin
      run = 0;
      last = 0;
    end else begin
      if (Gate) run++;
      else begin
        if (run != 0) last = run;
        run = 0;
      end
      if (Latch) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_latch: got latch with empty queue (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latch_gate_len", last, e.glen);
          chk("latch_meascount", int'(MeasCount), e.meas);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
  endtask

  // Counts rising edges with Busy high until it drops; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk);
      if (Busy) n++;
      else if (n > 0) return;
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic start_pulse();
    Start = 1'b0;
    tick(1);
    Start = 1'b1;
  endtask

  task automatic do_reset();
    Start = 1'b0;
    Stop = 1'b0;
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    exp_meas = 0;
    tick(1);
  endtask

  task automatic test_reset_mid_gate();
    start_pulse();
    tick(4);
    #2 Reset = 1'b1;
    #1;
    chk("rst_gate", int'(Gate), 0);
    chk("rst_latch", int'(Latch), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_meas", int'(MeasCount), 0);
    Start = 1'b0;
    tick(1);
    Reset = 1'b0;
    exp_meas = 0;
    tick(3);
    chk("post_rst_busy", int'(Busy), 0);
    chk("post_rst_gate", int'(Gate), 0);
  endtask

  task automatic test_stop();
    start_pulse();
    tick(5);
    chk("stop_pre_gate", int'(Gate), 1);
    Stop = 1'b1;
    tick(1);
    chk("stop_gate", int'(Gate), 0);
    chk("stop_latch", int'(Latch), 0);
    chk("stop_busy", int'(Busy), 0);
    chk("stop_meas", int'(MeasCount), exp_meas);
    Stop = 1'b0;
    tick(2);
    // Stop coincident with a Start rise in IDLE wins.
    start_pulse();
    Stop = 1'b1;
    tick(1);
    Stop = 1'b0;
    tick(2);
    chk("stop_vs_start_busy", int'(Busy), 0);
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    #1;
    chk("reset_gate", int'(Gate), 0);
    chk("reset_latch", int'(Latch), 0);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_meas", int'(MeasCount), 0);
    tick(2);
    Reset = 1'b0;
    tick(1);

`ifndef AUTO_RESTART_EN
    // Single measurement, Start held high afterwards.
    start_pulse();
    q.push_back('{GC, exp_meas});
    wait_idle(n);
    chk("busy_len", n, GC + 1 + HC);
    exp_meas = (exp_meas + 1) % (1 << MS);
    chk("single_meas", int'(MeasCount), exp_meas);
    tick(20);
    chk("no_second_window", int'(Busy), 0);

    test_reset_mid_gate();
    test_stop();

    // Start re-pulsed during GATE and HOLD is ignored.
    start_pulse();
    q.push_back('{GC, exp_meas});
    tick(3);  Start = 1'b0;
    tick(1);  Start = 1'b1;
    tick(3);  Start = 1'b0;
    tick(1);  Start = 1'b1;
    tick(4);  Start = 1'b0;
    tick(1);  Start = 1'b1;
    wait_idle(n);
    exp_meas = (exp_meas + 1) % (1 << MS);
    chk("repulse_meas", int'(MeasCount), exp_meas);
    tick(10);
    chk("repulse_idle", int'(Busy), 0);

    // Wrap: 1,2,3,0,1.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      start_pulse();
      q.push_back('{GC, exp_meas});
      wait_idle(n);
      exp_meas = (exp_meas + 1) % (1 << MS);
      chk("wrap_meas", int'(MeasCount), exp_meas);
    end
`else
    test_stop();
    begin
      int lc [5];
      bit seen;
      start_pulse();
      for (int k = 0; k < 5; k++) q.push_back('{GC, (exp_meas + k) % (1 << MS)});
      for (int k = 0; k < 5; k++) begin
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
          @(posedge Clk);
          if (Latch) seen = 1'b1;
        end
        lc[k] = cyc;
        chk("auto_latch_seen", int'(seen), 1);
        if (k > 0) chk("auto_period", lc[k] - lc[k-1], GC + 1 + HC);
      end
      tick(1);
      Stop = 1'b1;
      tick(1);
      Stop = 1'b0;
      chk("auto_stop_busy", int'(Busy), 0);
      chk("auto_stop_gate", int'(Gate), 0);
      exp_meas = (exp_meas + 5) % (1 << MS);
      chk("auto_meas", int'(MeasCount), exp_meas);
      tick(20);
      chk("auto_stays_idle", int'(Busy), 0);
    end
    test_reset_mid_gate();
`endif

    tick(3);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1);
  end

endmodule
